// File: rtl/dense_classifier_if.sv
// Host/ROM-side bus of the dense classifier: frame control, pooled-feature
// stream, weight ROM port and result outputs.
interface dense_classifier_if;
  logic        start;
  logic        valid_in;
  logic [7:0]  in1, in2, in3, in4, in5, in6, in7, in8;
  logic [9:0]  w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;
  logic [2:0]  class_out;
  logic [15:0] score_out;

  modport master (
    output start, valid_in, in1, in2, in3, in4, in5, in6, in7, in8, w_data,
    input  w_addr, busy, done, class_out, score_out
  );

  modport slave (
    input  start, valid_in, in1, in2, in3, in4, in5, in6, in7, in8, w_data,
    output w_addr, busy, done, class_out, score_out
  );
endinterface

// File: rtl/dense_classifier.sv
// Fully-connected classifier head: buffers one pooled frame, runs one MAC per
// cycle against the weight ROM for every class and reports the arg-max class.
module dense_classifier #(
  parameter int NFEAT  = 160,
  parameter int NCLASS = 5,
  parameter int ACCW   = 24
) (
  input logic               clk,
  input logic               rst,
  dense_classifier_if.slave bus
);
  localparam int NCH  = 8;
  localparam int NPOS = NFEAT / NCH;
  localparam int PW   = $clog2(NPOS);
  localparam int FW   = $clog2(NFEAT);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, CMP, DONE} state_t;
  state_t state, nxt;

  logic [PW-1:0]          pos;
  logic [FW-1:0]          fcnt, f_d;
  logic [2:0]             cls, best_cls;
  logic [1:0]             vld_pipe;
  logic signed [ACCW-1:0] acc, sum;
  logic signed [15:0]     score, best_score, sat;
  logic signed [16:0]     wext, fext, prod;
  logic [NCH-1:0][7:0]    chan;
  logic [7:0]             feat [NFEAT];
  logic                   better;

  assign chan = {bus.in8, bus.in7, bus.in6, bus.in5,
                 bus.in4, bus.in3, bus.in2, bus.in1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = LOAD;
      LOAD:    if (bus.valid_in && pos == PW'(NPOS-1)) nxt = CALC;
      CALC:    if (fcnt == FW'(NFEAT-1)) nxt = DRAIN;
      DRAIN:   nxt = CMP;
      CMP:     nxt = (cls == 3'(NCLASS-1)) ? DONE : CALC;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    bus.w_addr = '0;
    if (state == CALC) bus.w_addr = 10'(cls) * 10'(NFEAT) + 10'(fcnt);
  end

  // Product lines up with w_data, which arrives one cycle after its address.
  assign wext = 17'($signed(bus.w_data));
  assign fext = {9'b0, feat[f_d]};
  assign prod = wext * fext;
  assign sum  = acc + ACCW'(prod);

  always_comb begin
    if (sum > ACCW'(32767))       sat = 16'sh7fff;
    else if (sum < ACCW'(-32768)) sat = -16'sh8000;
    else                          sat = sum[15:0];
  end

  assign better = (cls == 3'd0) || (score > best_score);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos           <= '0;
      fcnt          <= '0;
      f_d           <= '0;
      cls           <= '0;
      vld_pipe      <= '0;
      acc           <= '0;
      score         <= '0;
      best_score    <= '0;
      best_cls      <= '0;
      bus.class_out <= '0;
      bus.score_out <= '0;
    end else begin
      // [0]: address issued this cycle, [1]: its product is on w_data now
      vld_pipe <= {vld_pipe[0], nxt == CALC};
      acc      <= vld_pipe[1] ? sum : '0;
      if (vld_pipe[1] && !vld_pipe[0]) score <= sat;
      f_d  <= fcnt;
      fcnt <= (state == CALC && fcnt != FW'(NFEAT-1)) ? fcnt + FW'(1) : '0;

      if (state == LOAD && bus.valid_in)
        pos <= (pos == PW'(NPOS-1)) ? '0 : pos + PW'(1);
      else if (state == IDLE)
        pos <= '0;

      if (state == LOAD) cls <= '0;
      if (state == CMP) begin
        cls <= cls + 3'd1;
        if (better) begin
          best_score <= score;
          best_cls   <= cls;
        end
        if (cls == 3'(NCLASS-1)) begin
          bus.class_out <= better ? cls : best_cls;
          bus.score_out <= better ? score : best_score;
        end
      end
    end
  end

  // Every frame rewrites all entries before CALC, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.valid_in)
      for (int k = 0; k < NCH; k++) feat[int'(pos)*NCH + k] <= chan[k];
  end
endmodule

// File: tb/tb_dense_classifier.sv
// Directed and golden-model checks of dense_classifier with a registered ROM.
module tb_dense_classifier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dense_classifier_if bus();

  dense_classifier #(.NFEAT(160), .NCLASS(5), .ACCW(24)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [7:0] rom [1024];
  logic [7:0] ftab [160];
  always @(posedge clk) bus.w_data <= rom[bus.w_addr];

  int total, bad;
  int lat, wa5, wa161, wa172, ec, es;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic put(input int p);
    bus.in1 = ftab[p*8+0]; bus.in2 = ftab[p*8+1];
    bus.in3 = ftab[p*8+2]; bus.in4 = ftab[p*8+3];
    bus.in5 = ftab[p*8+4]; bus.in6 = ftab[p*8+5];
    bus.in7 = ftab[p*8+6]; bus.in8 = ftab[p*8+7];
  endtask

  task automatic put_junk();
    bus.in1 = 8'($urandom_range(0, 255)); bus.in2 = 8'($urandom_range(0, 255));
    bus.in3 = 8'($urandom_range(0, 255)); bus.in4 = 8'($urandom_range(0, 255));
    bus.in5 = 8'($urandom_range(0, 255)); bus.in6 = 8'($urandom_range(0, 255));
    bus.in7 = 8'($urandom_range(0, 255)); bus.in8 = 8'($urandom_range(0, 255));
  endtask

  // n counts cycles after the one that presents the 20th sample.
  task automatic send_frame(input int gmax, input int poke, input int abort_n);
    bus.valid_in = 1'b1; put_junk();          // stray sample while IDLE
    @(posedge clk); #1;
    bus.start = 1'b1;                          // valid_in still high: ignored
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int p = 0; p < 20; p++) begin
      repeat ($urandom_range(0, gmax)) begin
        bus.valid_in = 1'b0; put_junk();
        @(posedge clk); #1;
      end
      bus.valid_in = 1'b1; put(p);
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    lat = -1; wa5 = -1; wa161 = -1; wa172 = -1;
    for (int n = 1; n <= 1000; n++) begin
      if (n == 5)   wa5   = int'(bus.w_addr);
      if (n == 161) wa161 = int'(bus.w_addr);
      if (n == 172) wa172 = int'(bus.w_addr);
      if (bus.done) begin lat = n; break; end
      bus.start = (n == poke);
      rst       = (n == abort_n);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int ecls, input int escore);
    chk({nm, "_latency"}, lat, 811);
    chk({nm, "_class"}, int'(bus.class_out), ecls);
    chk({nm, "_score"}, int'($signed(bus.score_out)), escore);
    chk({nm, "_busy_in_done"}, int'(bus.busy), 1);
    chk({nm, "_waddr_done"}, int'(bus.w_addr), 0);
    chk({nm, "_waddr_c0f4"}, wa5, 4);
    chk({nm, "_waddr_drain"}, wa161, 0);
    chk({nm, "_waddr_c1f9"}, wa172, 169);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(bus.done), 0);
    chk({nm, "_busy_idle"}, int'(bus.busy), 0);
    repeat (3) @(posedge clk); #1;
    chk({nm, "_class_hold"}, int'(bus.class_out), ecls);
    chk({nm, "_score_hold"}, int'($signed(bus.score_out)), escore);
  endtask

  task automatic model(output int bc, output int bs);
    int s, w;
    bc = 0; bs = 0;
    for (int c = 0; c < 5; c++) begin
      s = 0;
      for (int f = 0; f < 160; f++) begin
        w = int'($signed(rom[c*160+f]));
        s += w * int'(ftab[f]);
      end
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (c == 0 || s > bs) begin bs = s; bc = c; end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; bus.start = 1'b1; bus.valid_in = 1'b0; put_junk();
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    repeat (3) @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_class", int'(bus.class_out), 0);
    chk("rst_score", int'(bus.score_out), 0);
    chk("rst_waddr", int'(bus.w_addr), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst_start", int'(bus.busy), 0);

    // features 1, weight = class index: scores 0,160,320,480,640
    for (int f = 0; f < 160; f++) ftab[f] = 8'd1;
    for (int c = 0; c < 5; c++)
      for (int f = 0; f < 160; f++) rom[c*160+f] = 8'(c);
    send_frame(0, 0, 0);
    check_frame("ramp", 4, 640);

    // all equal scores 7*3*160=3360: lowest index wins; start poked mid-CALC
    for (int f = 0; f < 160; f++) ftab[f] = 8'd7;
    for (int i = 0; i < 800; i++) rom[i] = 8'd3;
    send_frame(5, 100, 0);
    check_frame("tie", 0, 3360);

    // saturation both ways
    for (int f = 0; f < 160; f++) ftab[f] = 8'd255;
    for (int c = 0; c < 5; c++)
      for (int f = 0; f < 160; f++) rom[c*160+f] = (c == 2) ? 8'h7f : 8'h80;
    send_frame(2, 0, 0);
    check_frame("sat", 2, 32767);

    // random frame against the golden model, with and without gaps
    for (int f = 0; f < 160; f++) ftab[f] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 800; i++) rom[i] = 8'($urandom_range(0, 255));
    model(ec, es);
    send_frame(0, 0, 0);
    check_frame("rnd", ec, es);
    send_frame(5, 300, 0);
    check_frame("rnd_gaps", ec, es);

    // reset in class 3 CALC, then a clean frame
    send_frame(3, 0, 536);
    chk("abort_no_done", lat, -1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_class", int'(bus.class_out), 0);
    chk("abort_score", int'(bus.score_out), 0);
    chk("abort_waddr", int'(bus.w_addr), 0);
    send_frame(0, 0, 0);
    check_frame("post_abort", ec, es);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
